// File: rtl/fir_par_prog.sv
// -----------------------------------------------------------------------------
// fir_par_prog -- L-way parallel, N-tap programmable FIR filter.
//
// Every accepted beat carries L consecutive samples. All L outputs of a beat
// are computed in the same cycle from one shared window: the last N-1
// accepted samples followed by the L new ones. Products are accumulated at
// full precision. The result is then rounded (half toward +inf), shifted
// right by SHIFT and saturated to DW bits, separately for each slice.
//
// Latency is two cycles. Stage 1 registers the full-precision sums. Stage 2
// registers the rounded and saturated outputs.
//
// Ports
//   clk        in   1        sole clock, rising edge
//   rst        in   1        synchronous, active-high reset
//   in_valid   in   1        x_in carries a valid beat this cycle
//   x_in       in   L*DW     packed samples, slice 0 = oldest
//   flush      in   1        clear sample history, coefficients kept
//   coef_we    in   1        coefficient write strobe
//   coef_addr  in   AW       tap index to write (>= N is ignored)
//   coef_data  in   CW       coefficient value (two's complement)
//   out_valid  out  1        y_out valid (in_valid delayed by 2)
//   y_out      out  L*DW     packed outputs, same slice order as x_in
// -----------------------------------------------------------------------------
module fir_par_prog #(
  parameter int DW    = 16,
  parameter int CW    = 16,
  parameter int L     = 3,
  parameter int N     = 8,
  parameter int SHIFT = 15,
  localparam int AW   = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [L*DW-1:0] x_in,
  input  logic            flush,
  input  logic            coef_we,
  input  logic [AW-1:0]   coef_addr,
  input  logic [CW-1:0]   coef_data,
  output logic            out_valid,
  output logic [L*DW-1:0] y_out
);

  localparam int ACC = DW + CW + $clog2(N);
  localparam int WIN = N - 1 + L;

  // Reset value of h[0] is unity gain (2^SHIFT). It is capped to the largest
  // positive coefficient when 2^SHIFT does not fit in CW bits.
  localparam logic signed [CW-1:0] H0_RST =
    (SHIFT >= CW - 1) ? {1'b0, {(CW-1){1'b1}}} : (CW'(1) << SHIFT);

  localparam logic signed [ACC:0] RND     = (ACC+1)'(1) << (SHIFT - 1);
  localparam logic signed [ACC:0] SAT_MAX = {{(ACC+2-DW){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACC:0] SAT_MIN = {{(ACC+2-DW){1'b1}}, {(DW-1){1'b0}}};
  localparam logic [AW:0]         N_TAPS  = (AW+1)'(N);

  logic signed [CW-1:0]  r_coef [N];
  logic signed [DW-1:0]  r_hist [N-1];   // index 0 = oldest sample
  logic signed [ACC-1:0] r_acc  [L];
  logic                  r_v1;

  logic signed [DW-1:0]  w_win      [WIN];
  logic signed [DW-1:0]  w_hist_nxt [N-1];
  logic signed [ACC-1:0] w_acc      [L];
  logic [L*DW-1:0]       w_y;

  // Sample window: history (zeroed by flush), then the incoming slices.
  // The next history is the newest N-1 entries of this window.
  always_comb begin
    for (int m = 0; m < N - 1; m++) begin
      w_win[m] = flush ? '0 : r_hist[m];
    end
    for (int i = 0; i < L; i++) begin
      w_win[N-1+i] = x_in[i*DW +: DW];
    end
    for (int m = 0; m < N - 1; m++) begin
      w_hist_nxt[m] = w_win[m+L];
    end
  end

  // y(Lk+i) needs x(Lk+i-j), which is window entry N-1+i-j.
  // Operands are sign-extended to ACC bits before the multiply, so nothing is
  // truncated along the way.
  always_comb begin
    for (int i = 0; i < L; i++) begin
      // NOTE: blocking assignments in combinational logic let the running sum
      // update within one pass. The local starts at zero each iteration, so
      // no latch is inferred.
      logic signed [ACC-1:0] sum;
      sum = '0;
      for (int j = 0; j < N; j++) begin
        sum = sum + ACC'(w_win[N-1+i-j]) * ACC'(r_coef[j]);
      end
      w_acc[i] = sum;
    end
  end

  // Round half toward +inf, arithmetic shift, then saturate each slice.
  always_comb begin
    w_y = '0;
    for (int i = 0; i < L; i++) begin
      logic signed [ACC:0] ext;
      logic signed [ACC:0] rnd;
      logic signed [ACC:0] shr;
      ext = {r_acc[i][ACC-1], r_acc[i]};
      rnd = ext + RND;
      shr = rnd >>> SHIFT;
      if (shr > SAT_MAX) begin
        w_y[i*DW +: DW] = SAT_MAX[DW-1:0];
      end else if (shr < SAT_MIN) begin
        w_y[i*DW +: DW] = SAT_MIN[DW-1:0];
      end else begin
        w_y[i*DW +: DW] = shr[DW-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the coefficient memory is reset explicitly. The filter must come
      // out of reset as a known unity-gain pass-through, not with random taps.
      for (int j = 0; j < N; j++) begin
        r_coef[j] <= '0;
      end
      r_coef[0] <= H0_RST;
      for (int m = 0; m < N - 1; m++) begin
        r_hist[m] <= '0;
      end
      for (int i = 0; i < L; i++) begin
        r_acc[i] <= '0;
      end
      r_v1      <= 1'b0;
      out_valid <= 1'b0;
      y_out     <= '0;
    end else begin
      // A beat in the same cycle as a write already read the old value.
      if (coef_we && ({1'b0, coef_addr} < N_TAPS)) begin
        r_coef[coef_addr] <= coef_data;
      end

      // Bubbles leave history untouched. The flush zeroing is already folded
      // into w_hist_nxt when a beat arrives together with flush.
      if (in_valid) begin
        r_hist <= w_hist_nxt;
      end else if (flush) begin
        for (int m = 0; m < N - 1; m++) begin
          r_hist[m] <= '0;
        end
      end

      r_v1 <= in_valid;
      if (in_valid) begin
        r_acc <= w_acc;
      end

      out_valid <= r_v1;
      if (r_v1) begin
        y_out <= w_y;
      end
    end
  end

endmodule

// File: tb/tb_fir_par_prog.sv
// -----------------------------------------------------------------------------
// tb_fir_par_prog -- directed bench for fir_par_prog with default parameters
// (DW=16, CW=16, L=3, N=8, SHIFT=15). Inputs change 1 ns after a rising edge.
// Outputs are sampled at that same point.
// -----------------------------------------------------------------------------
module tb_fir_par_prog;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [47:0] x_in;
  logic        flush;
  logic        coef_we;
  logic [2:0]  coef_addr;
  logic [15:0] coef_data;
  logic        out_valid;
  logic [47:0] y_out;

  int n_checks = 0;
  int n_fail   = 0;

  fir_par_prog #(
    .DW(16), .CW(16), .L(3), .N(8), .SHIFT(15)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .x_in      (x_in),
    .flush     (flush),
    .coef_we   (coef_we),
    .coef_addr (coef_addr),
    .coef_data (coef_data),
    .out_valid (out_valid),
    .y_out     (y_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [47:0] pack3(input int a, input int b, input int c);
    return {16'(c), 16'(b), 16'(a)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    rst       = 1'b0;
    in_valid  = 1'b0;
    flush     = 1'b0;
    coef_we   = 1'b0;
    coef_addr = '0;
    coef_data = '0;
    x_in      = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic wr_coef(input int addr, input int data);
    coef_we   = 1'b1;
    coef_addr = 3'(addr);
    coef_data = 16'(data);
    tick();
    coef_we   = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst       = 1'b1;
    in_valid  = 1'b1;
    flush     = 1'b1;
    coef_we   = 1'b1;
    x_in      = pack3(1234, -5678, 999);
    tick();
    clear_inputs();
    n_checks++;
    if (out_valid !== 1'b0 || y_out !== 48'h0) begin
      n_fail++;
      $display("FAIL reset_state: out_valid=%0b y_out=%h, expected 0 and 0", out_valid, y_out);
    end
    tick();
    n_checks++;
    if (out_valid !== 1'b0 || y_out !== 48'h0) begin
      n_fail++;
      $display("FAIL reset_discard1: out_valid=%0b y_out=%h, expected 0 and 0", out_valid, y_out);
    end
    tick();
    n_checks++;
    if (out_valid !== 1'b0 || y_out !== 48'h0) begin
      n_fail++;
      $display("FAIL reset_discard2: out_valid=%0b y_out=%h, expected 0 and 0", out_valid, y_out);
    end
  endtask

  // Two-tap average: back-to-back beats, latency and output hold.
  task automatic test_passthrough();
    do_reset();
    wr_coef(0, 16384);
    wr_coef(1, 16384);
    in_valid = 1'b1;
    x_in     = pack3(1000, 2000, 3000);
    tick();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL pass_latency: out_valid=%0b, expected 0 one cycle after beat", out_valid);
    end
    x_in = pack3(4000, 5000, 6000);
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || y_out !== pack3(500, 1500, 2500)) begin
      n_fail++;
      $display("FAIL pass_beat1: out_valid=%0b y_out=%h, expected 1 and %h",
               out_valid, y_out, pack3(500, 1500, 2500));
    end
    tick();
    n_checks++;
    if (out_valid !== 1'b1 || y_out !== pack3(3500, 4500, 5500)) begin
      n_fail++;
      $display("FAIL pass_beat2: out_valid=%0b y_out=%h, expected 1 and %h",
               out_valid, y_out, pack3(3500, 4500, 5500));
    end
    tick();
    n_checks++;
    if (out_valid !== 1'b0 || y_out !== pack3(3500, 4500, 5500)) begin
      n_fail++;
      $display("FAIL pass_hold: out_valid=%0b y_out=%h, expected 0 and %h",
               out_valid, y_out, pack3(3500, 4500, 5500));
    end
  endtask

  // h[0]=0.5: rounding half toward +inf, including a negative operand.
  task automatic test_rounding();
    do_reset();
    wr_coef(0, 16384);
    in_valid = 1'b1;
    x_in     = pack3(3, -3, 1);
    tick();
    in_valid = 1'b0;
    tick();
    n_checks++;
    if (out_valid !== 1'b1 || y_out !== pack3(2, -1, 1)) begin
      n_fail++;
      $display("FAIL round: out_valid=%0b y_out=%h, expected 1 and %h",
               out_valid, y_out, pack3(2, -1, 1));
    end
  endtask

  task automatic test_saturation();
    logic [47:0] exp_y [4];
    exp_y[0] = pack3(32766, 32767, 32767);     // slice 0 sees zero history
    exp_y[1] = pack3(32767, 32767, 32767);
    exp_y[2] = pack3(-1, -32768, -32768);      // 32767*(32767-32768) -> -1
    exp_y[3] = pack3(-32768, -32768, -32768);
    do_reset();
    wr_coef(0, 32767);
    wr_coef(1, 32767);
    in_valid = 1'b1;
    x_in     = pack3(32767, 32767, 32767);
    tick();
    for (int k = 0; k < 4; k++) begin
      in_valid = (k < 3);
      x_in     = (k < 1) ? pack3(32767, 32767, 32767) : pack3(-32768, -32768, -32768);
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || y_out !== exp_y[k]) begin
        n_fail++;
        $display("FAIL sat_beat%0d: out_valid=%0b y_out=%h, expected 1 and %h",
                 k, out_valid, y_out, exp_y[k]);
      end
    end
  endtask

  // Valid pattern 1,0,0,1,1 then flush+beat. Bubbles must be transparent, and
  // the flush must not cancel the beat already in flight.
  task automatic test_bubbles_flush();
    logic        v_pat [7];
    logic [47:0] x_pat [7];
    logic        f_pat [7];
    logic        ev    [7];
    logic [47:0] ey    [7];
    v_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    f_pat = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    x_pat[0] = pack3(1000, 2000, 3000);
    x_pat[1] = pack3(11, 22, 33);
    x_pat[2] = pack3(44, 55, 66);
    x_pat[3] = pack3(4000, 5000, 6000);
    x_pat[4] = pack3(7000, 8000, 9000);
    x_pat[5] = pack3(1000, 2000, 3000);
    x_pat[6] = pack3(0, 0, 0);
    ev = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    ey[0] = 48'h0;
    ey[1] = pack3(500, 1500, 2500);
    ey[2] = pack3(500, 1500, 2500);
    ey[3] = pack3(500, 1500, 2500);
    ey[4] = pack3(3500, 4500, 5500);
    ey[5] = pack3(6500, 7500, 8500);
    ey[6] = pack3(500, 1500, 2500);
    do_reset();
    wr_coef(0, 16384);
    wr_coef(1, 16384);
    for (int k = 0; k < 7; k++) begin
      in_valid = v_pat[k];
      flush    = f_pat[k];
      x_in     = x_pat[k];
      tick();
      flush    = 1'b0;
      in_valid = 1'b0;
      n_checks++;
      if (out_valid !== ev[k] || y_out !== ey[k]) begin
        n_fail++;
        $display("FAIL bubble_cyc%0d: out_valid=%0b y_out=%h, expected %0b and %h",
                 k, out_valid, y_out, ev[k], ey[k]);
      end
    end
  endtask

  // Reset one cycle after a beat, together with a coefficient write and a
  // beat. Reset must win over both, and the in-flight beat is discarded.
  task automatic test_mid_reset();
    do_reset();
    wr_coef(0, 16384);
    wr_coef(1, 16384);
    in_valid = 1'b1;
    x_in     = pack3(5000, 5000, 5000);
    tick();
    rst       = 1'b1;
    coef_we   = 1'b1;
    coef_addr = 3'd0;
    coef_data = 16'd0;
    x_in      = pack3(9999, 9999, 9999);
    tick();
    clear_inputs();
    n_checks++;
    if (out_valid !== 1'b0 || y_out !== 48'h0) begin
      n_fail++;
      $display("FAIL midrst_cyc1: out_valid=%0b y_out=%h, expected 0 and 0", out_valid, y_out);
    end
    tick();
    n_checks++;
    if (out_valid !== 1'b0 || y_out !== 48'h0) begin
      n_fail++;
      $display("FAIL midrst_cyc2: out_valid=%0b y_out=%h, expected 0 and 0", out_valid, y_out);
    end
    in_valid = 1'b1;
    x_in     = pack3(100, -200, 300);
    tick();
    in_valid = 1'b0;
    tick();
    n_checks++;
    if (out_valid !== 1'b1 || y_out !== pack3(100, -200, 300)) begin
      n_fail++;
      $display("FAIL midrst_unity: out_valid=%0b y_out=%h, expected 1 and %h",
               out_valid, y_out, pack3(100, -200, 300));
    end
  endtask

  // Beat A shares its cycle with a write of h[0]=0, so it uses the old h[0].
  // Beat B in the next cycle sees all-zero taps.
  task automatic test_coef_timing();
    do_reset();
    in_valid  = 1'b1;
    x_in      = pack3(100, -200, 300);
    coef_we   = 1'b1;
    coef_addr = 3'd0;
    coef_data = 16'd0;
    tick();
    coef_we = 1'b0;
    x_in    = pack3(1000, 2000, 3000);
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || y_out !== pack3(100, -200, 300)) begin
      n_fail++;
      $display("FAIL coef_old: out_valid=%0b y_out=%h, expected 1 and %h",
               out_valid, y_out, pack3(100, -200, 300));
    end
    tick();
    n_checks++;
    if (out_valid !== 1'b1 || y_out !== 48'h0) begin
      n_fail++;
      $display("FAIL coef_new: out_valid=%0b y_out=%h, expected 1 and 0", out_valid, y_out);
    end
  endtask

  initial begin
    clear_inputs();
    tick();
    test_reset();
    test_passthrough();
    test_rounding();
    test_saturation();
    test_bubbles_flush();
    test_mid_reset();
    test_coef_timing();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
